axi_lite_arbiter: RTL
=====================

// Module: axi_lite_arbiter
// PURPOSE
//  2:1 AXI-Lite arbiter placed directly upstream of the SRAM slave.
//  m0 = IFU (read-only master), m1 = LSU (read/write master), s = SRAM slave port.
//  Grants one whole transaction at a time; the slave accepts only one outstanding op.
// PARAMETERS
//  ADDR_W  32  address width on all ports
//  DATA_W  32  data width on all ports (wstrb = DATA_W/8)
// PORTS
//  clk                                  in   1     system clock
//  rst                                  in   1     synchronous reset, active-low
//  m0_araddr,m0_arvalid,m0_rready       in   32,1,1    IFU AR/R inputs
//  m0_arready,m0_rdata,m0_rresp,m0_rvalid out 1,32,2,1 IFU AR/R outputs
//  m1_araddr,arvalid,rready,awaddr,awvalid,wdata,wstrb,wvalid,bready  in  32,1,1,32,1,32,4,1,1
//  m1_arready,rdata,rresp,rvalid,awready,wready,bresp,bvalid  out  1,32,2,1,1,1,2,1
//  s_araddr,arvalid,rready,awaddr,awvalid,wdata,wstrb,wvalid,bready   out same widths as m1 inputs
//  s_arready,rdata,rresp,rvalid,awready,wready,bresp,bvalid   in  same widths as m1 outputs
// BEHAVIOUR
//  - State reg: IDLE, M0_RD, M1_RD, M1_WR. Reset (rst==0 at posedge) -> IDLE.
//  - In IDLE every output valid/ready to masters and slave is 0; s_* addr/data/strb 0.
//  - Requests: r0=m0_arvalid, r1r=m1_arvalid, r1w=m1_awvalid&m1_wvalid.
//  - IDLE arbitration (registered, 1 cycle): default fixed priority r1r > r1w > r0.
//    LSU read wins over LSU write when both asserted same cycle.
//  - Granted state: granted master's channels wired combinationally to s_*;
//    all other master ready/valid outputs held 0; rdata/rresp/bresp to non-granted = 0.
//  - M1_WR forwards awvalid and wvalid together; never asserts s_arvalid.
//  - Read states never assert s_awvalid/s_wvalid (slave must see only one request kind).
//  - Exit: M0_RD/M1_RD -> IDLE on s_rvalid&granted rready (cycle of R handshake);
//    M1_WR -> IDLE on s_bvalid&m1_bready. Next grant earliest the following cycle.
//  - Min latency added: 1 cycle from master valid to s_*valid; 0 on response path.
//  - Masters must hold valid/addr until ready (AXI rule); arbiter does not buffer.
//  - Request dropped by a master before grant: ignored, stays IDLE.
//  - Reset mid-transaction: back to IDLE, outputs to reset values; slave shares rst.
//  - rresp/bresp passed through unmodified.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined: 1-bit last_grant pointer (reset = m1); when r0 and
//   (r1r|r1w) contend, master not granted last wins; pointer updates on each grant.
//   Within m1, read still precedes write.
//  Undefined: fixed priority as above; IFU can starve under continuous LSU traffic.
// STRUCTURE
//  Package axi_lite_pkg: resp codes (OKAY=2'b00, SLVERR=2'b10), arb state enum,
//   ADDR_W/DATA_W defaults.
//  One sub-module axi_lite_arb_pick: combinational picker (r0,r1r,r1w,last_grant)
//   -> next state; top holds state reg, pointer and channel muxing.
// TESTING
//  1 m0 read 0x8000_0000 alone -> s_araddr=0x8000_0000 one cycle later; m0 gets
//    slave rdata, rresp=0; m1 outputs stay 0 throughout.
//  2 m1 write addr 0x8000_0010 data 0xDEADBEEF strb 4'b0011 -> s_aw/w forwarded
//    together, s_arvalid=0; m1_bvalid on slave B; back to IDLE next cycle.
//  3 m0 read and m1 read same cycle, fixed priority -> m1 served first, m0 granted
//    cycle after m1 R handshake; m0 valid held entire time.
//  4 m1 arvalid and awvalid+wvalid together -> read completes first, then write.
//  5 ARB_ROUND_ROBIN_EN: m0 and m1 reads back-to-back x4 -> grants alternate m0,m1,m0,m1.
//  6 rst low while in M1_WR before bvalid -> next cycle state IDLE, all valids 0,
//    fresh m0 read afterwards completes normally.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// -----------------------------------------------------------------------------
// axi_lite_pkg
// Shared definitions for the IFU/LSU -> SRAM AXI-Lite arbiter:
//   - default address/data widths
//   - AXI response codes
//   - arbiter state encoding and last-grant pointer values
// No ports (package).
// -----------------------------------------------------------------------------
package axi_lite_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_M0_RD = 2'd1,
    ST_M1_RD = 2'd2,
    ST_M1_WR = 2'd3
  } arb_state_e;

  // Values of the round-robin pointer: which master received the last grant.
  localparam logic GRANT_M0 = 1'b0;
  localparam logic GRANT_M1 = 1'b1;

endpackage

// File: rtl/axi_lite_arb_pick.sv
// -----------------------------------------------------------------------------
// axi_lite_arb_pick
// Combinational picker: given the current requests, chooses which transaction
// the arbiter will own next when it is idle.
// Ports:
//   r0         in   IFU read request  (m0_arvalid)
//   r1r        in   LSU read request  (m1_arvalid)
//   r1w        in   LSU write request (m1_awvalid & m1_wvalid)
//   last_grant in   master granted most recently (GRANT_M0 / GRANT_M1)
//   pick       out  next arbiter state (ST_IDLE when nothing is requested)
// Configuration macro: ARB_ROUND_ROBIN_EN
//   defined   -> IFU vs LSU contention resolved by last_grant (alternating)
//   undefined -> fixed priority LSU read > LSU write > IFU read
// -----------------------------------------------------------------------------
module axi_lite_arb_pick
  import axi_lite_pkg::*;
(
  input  logic       r0,
  input  logic       r1r,
  input  logic       r1w,
  input  logic       last_grant,
  output arb_state_e pick
);

  logic       r1_any;
  arb_state_e m1_pick;

  assign r1_any = r1r | r1w;

  always_comb begin
    // Inside the LSU the read always goes ahead of the write.
    m1_pick = r1r ? ST_M1_RD : ST_M1_WR;
    pick    = ST_IDLE;
`ifdef ARB_ROUND_ROBIN_EN
    if (r0 && r1_any) begin
      pick = (last_grant == GRANT_M1) ? ST_M0_RD : m1_pick;
    end else if (r1_any) begin
      pick = m1_pick;
    end else if (r0) begin
      pick = ST_M0_RD;
    end
`else
    if (r1_any) begin
      pick = m1_pick;
    end else if (r0) begin
      pick = ST_M0_RD;
    end
`endif
  end

`ifndef ARB_ROUND_ROBIN_EN
  // Pointer only matters in round-robin builds.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/axi_lite_arbiter.sv
// -----------------------------------------------------------------------------
// axi_lite_arbiter
// 2:1 AXI-Lite arbiter in front of the SRAM slave. m0 is the IFU (read only),
// m1 is the LSU (read/write). One whole transaction is granted at a time; the
// granted master's channels are wired straight through to the slave port and
// everything else is held at zero.
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   m0_ar*/m0_r*                  IFU read address / read data channels
//   m1_ar*/m1_r*/m1_aw*/m1_w*/m1_b*  LSU read and write channels
//   s_*                           slave-side channels (same widths as m1)
// Parameters: ADDR_W, DATA_W (wstrb width = DATA_W/8)
// Configuration macro: ARB_ROUND_ROBIN_EN (round-robin IFU/LSU arbitration
//   with a 1-bit last-grant pointer; fixed priority when undefined)
// -----------------------------------------------------------------------------
module axi_lite_arbiter
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  // IFU
  input  logic [ADDR_W-1:0]   m0_araddr,
  input  logic                m0_arvalid,
  input  logic                m0_rready,
  output logic                m0_arready,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic [1:0]          m0_rresp,
  output logic                m0_rvalid,
  // LSU
  input  logic [ADDR_W-1:0]   m1_araddr,
  input  logic                m1_arvalid,
  input  logic                m1_rready,
  input  logic [ADDR_W-1:0]   m1_awaddr,
  input  logic                m1_awvalid,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic                m1_wvalid,
  input  logic                m1_bready,
  output logic                m1_arready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [1:0]          m1_rresp,
  output logic                m1_rvalid,
  output logic                m1_awready,
  output logic                m1_wready,
  output logic [1:0]          m1_bresp,
  output logic                m1_bvalid,
  // Slave
  output logic [ADDR_W-1:0]   s_araddr,
  output logic                s_arvalid,
  output logic                s_rready,
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic                s_awvalid,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_wvalid,
  output logic                s_bready,
  input  logic                s_arready,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic [1:0]          s_rresp,
  input  logic                s_rvalid,
  input  logic                s_awready,
  input  logic                s_wready,
  input  logic [1:0]          s_bresp,
  input  logic                s_bvalid
);

  arb_state_e state_reg;
  arb_state_e state_next;
  arb_state_e pick_state;
  logic       last_grant;

  axi_lite_arb_pick u_pick (
    .r0         (m0_arvalid),
    .r1r        (m1_arvalid),
    .r1w        (m1_awvalid & m1_wvalid),
    .last_grant (last_grant),
    .pick       (pick_state)
  );

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_reg;

  // Pointer moves only on the cycle a new owner is chosen.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant_reg <= GRANT_M1;
    end else if (state_reg == ST_IDLE && pick_state != ST_IDLE) begin
      last_grant_reg <= (pick_state == ST_M0_RD) ? GRANT_M0 : GRANT_M1;
    end
  end

  assign last_grant = last_grant_reg;
`else
  assign last_grant = GRANT_M1;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Ownership ends on the response handshake; the next grant is decided in
  // IDLE, so back-to-back transactions are separated by one idle cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  state_next = pick_state;
      ST_M0_RD: if (s_rvalid && m0_rready) state_next = ST_IDLE;
      ST_M1_RD: if (s_rvalid && m1_rready) state_next = ST_IDLE;
      ST_M1_WR: if (s_bvalid && m1_bready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Channel steering: only the owner's channels are connected, everything else
  // reads as zero so the slave never sees a read and a write request together.
  always_comb begin
    m0_arready = 1'b0;
    m0_rdata   = '0;
    m0_rresp   = RESP_OKAY;
    m0_rvalid  = 1'b0;
    m1_arready = 1'b0;
    m1_rdata   = '0;
    m1_rresp   = RESP_OKAY;
    m1_rvalid  = 1'b0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bresp   = RESP_OKAY;
    m1_bvalid  = 1'b0;
    s_araddr   = '0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    s_awaddr   = '0;
    s_awvalid  = 1'b0;
    s_wdata    = '0;
    s_wstrb    = '0;
    s_wvalid   = 1'b0;
    s_bready   = 1'b0;
    case (state_reg)
      ST_M0_RD: begin
        s_araddr   = m0_araddr;
        s_arvalid  = m0_arvalid;
        s_rready   = m0_rready;
        m0_arready = s_arready;
        m0_rdata   = s_rdata;
        m0_rresp   = s_rresp;
        m0_rvalid  = s_rvalid;
      end
      ST_M1_RD: begin
        s_araddr   = m1_araddr;
        s_arvalid  = m1_arvalid;
        s_rready   = m1_rready;
        m1_arready = s_arready;
        m1_rdata   = s_rdata;
        m1_rresp   = s_rresp;
        m1_rvalid  = s_rvalid;
      end
      ST_M1_WR: begin
        s_awaddr   = m1_awaddr;
        s_awvalid  = m1_awvalid;
        s_wdata    = m1_wdata;
        s_wstrb    = m1_wstrb;
        s_wvalid   = m1_wvalid;
        s_bready   = m1_bready;
        m1_awready = s_awready;
        m1_wready  = s_wready;
        m1_bresp   = s_bresp;
        m1_bvalid  = s_bvalid;
      end
      default: ;
    endcase
  end

endmodule
